uart_rx: RTL and testbench

- Serial UART receiver for the CPU's `rx` pin. It consumes the line driven by `uart_tx` / external host: 8N1, LSB first.
- Oversamples on the system clock, validates start and stop bits, and buffers bytes in a small FIFO.
- Presents bytes to the CPU's MMIO/interrupt logic through a valid/ready handshake, with error and interrupt flags.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding and the bit-period helper that both
// uart_rx and uart_tx use to turn a clock rate and baud rate into a
// number of system clocks per serial bit.
package uart_pkg;

    // Receiver frame states: waiting for a start edge, checking the start
    // bit, shifting in data bits, checking the stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Whole system clocks per serial bit (integer division, truncating).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO for uart_rx.
// Register array with read/write pointers one bit wider than the address so
// full and empty can be told apart; the head entry is read combinationally.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset (empties FIFO)
//   push, din   - write request and data; ignored when full unless popping
//   pop         - read request; ignored when empty
//   dout        - head entry, forced to 0 while empty
//   empty, full - occupancy status
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full when the pointers address the same slot but are a lap apart.
    // A push on a full FIFO is still accepted when a pop frees the head
    // slot in the same cycle.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointers advance on accepted operations and wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; stale entries are hidden by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// Oversamples the line on the system clock, checks start and stop bits,
// buffers good bytes in a small FIFO and hands them out with valid/ready.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   rx                  - asynchronous serial input, idle high
//   rx_data, rx_valid   - head-of-FIFO byte and FIFO-not-empty
//   rx_ready            - consumer pop (effective when rx_valid is high)
//   err_clr             - clears the sticky error flags
//   frame_err, overrun  - sticky: bad stop bit / good byte lost to a full FIFO
//   rx_busy             - receiver is inside a frame
//   irq                 - rx_valid | frame_err | overrun
module uart_rx #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy,
    output logic       irq
);
    import uart_pkg::*;

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);

    logic             rx_meta;
    logic             rxs;
    rx_state_t        state;
    rx_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             armed;
    logic             mid_hit;
    logic             full_hit;
    logic             stop_done;
    logic             good_stop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic. The start bit is checked at its middle so a short
    // glitch returns to IDLE; data and stop bits are then sampled one full
    // bit period apart, which keeps every sample near mid-bit. Leaving STOP
    // at the stop sample re-arms half a bit early for back-to-back frames.
    always_comb begin
        next_state = state;
        mid_hit    = (cnt == CNT_W'(CPB / 2 - 1));
        full_hit   = (cnt == CNT_W'(CPB - 1));
        stop_done  = 1'b0;
        good_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxs) next_state = START;
            end
            START: begin
                if (mid_hit) next_state = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (full_hit && bit_idx == 3'd7) next_state = STOP;
            end
            STOP: begin
                if (full_hit) begin
                    next_state = IDLE;
                    stop_done  = 1'b1;
                    good_stop  = rxs;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timing, bit index and shift register. Data arrives LSB first, so
    // each new bit enters at the top and the byte is aligned after eight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                START: begin
                    cnt     <= mid_hit ? '0 : cnt + 1'b1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (full_hit) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    cnt <= full_hit ? '0 : cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Arm flag: after a low stop bit (framing error or break) the line must
    // be seen high again before IDLE will accept another start edge, so a
    // held-low break produces exactly one error, not a stream of frames.
    always_ff @(posedge clk) begin
        if (reset)                  armed <= 1'b1;
        else if (stop_done && !rxs) armed <= 1'b0;
        else if (rxs)               armed <= 1'b1;
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    // Overrun only counts when no pop frees a slot in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_done && !rxs)                   frame_err <= 1'b1;
            else if (err_clr)                        frame_err <= 1'b0;
            if (good_stop && fifo_full && !pop)      overrun   <= 1'b1;
            else if (err_clr)                        overrun   <= 1'b0;
        end
    end

    assign pop      = rx_valid && rx_ready;
    assign rx_valid = !fifo_empty;
    assign rx_busy  = (state != IDLE);
    assign irq      = rx_valid | frame_err | overrun;

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (good_stop),
        .din   (shift),
        .pop   (pop),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (104 clocks/bit).
// Frames are driven bit by bit; a queue-based model of the FIFO and flags
// predicts what the receiver should present after each step.
module tb_uart_rx;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int CPB    = CLK_HZ / BAUD;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
    logic       irq;

    int         checks;
    int         errors;
    logic [7:0] model_q[$];
    logic       m_frame_err;
    logic       m_overrun;

    uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy),
        .irq       (irq)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n cycles, leaving time 1 unit after a rising edge.
    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every output with the model.
    task automatic checkState(input string tag, input logic exp_busy);
        logic exp_valid;
        exp_valid = (model_q.size() > 0);
        checkOutput({tag, "_valid"}, rx_valid, exp_valid);
        if (exp_valid) checkOutput({tag, "_data"}, rx_data, model_q[0]);
        checkOutput({tag, "_frame_err"}, frame_err, m_frame_err);
        checkOutput({tag, "_overrun"}, overrun, m_overrun);
        checkOutput({tag, "_irq"}, irq, exp_valid | m_frame_err | m_overrun);
        checkOutput({tag, "_busy"}, rx_busy, exp_busy);
    endtask

    // Model of a completed frame: an optional pop in the stop-sample cycle,
    // then the new byte is stored, lost to a full FIFO, or flagged bad.
    task automatic modelFrame(input logic [7:0] data, input logic stop_val,
                              input logic popped);
        if (popped) void'(model_q.pop_front());
        if (stop_val) begin
            if (model_q.size() < DEPTH) model_q.push_back(data);
            else                        m_overrun = 1'b1;
        end else begin
            m_frame_err = 1'b1;
        end
    endtask

    // Drive one 8N1 frame. pop_cycle >= 0 raises rx_ready so that the pop
    // lands on edge pop_cycle+1 of the frame; abort_cycle >= 0 stops driving
    // early without updating the model. rise_cycle reports the edge number
    // (counted from the start-bit drive) at which rx_valid first rose.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int pop_cycle, input int abort_cycle,
                                 output int rise_cycle);
        int   limit;
        int   b;
        logic prev_valid;
        logic popped;
        limit      = (abort_cycle >= 0) ? abort_cycle : 10 * CPB;
        rise_cycle = -1;
        prev_valid = rx_valid;
        popped     = 1'b0;
        for (int c = 0; c < limit; c++) begin
            b = c / CPB;
            if (b == 0)      rx = 1'b0;
            else if (b <= 8) rx = data[b-1];
            else             rx = stop_val;
            if (c == pop_cycle) begin
                checkOutput("sim_pop_valid", rx_valid, model_q.size() > 0);
                if (model_q.size() > 0) checkOutput("sim_pop_data", rx_data, model_q[0]);
                popped   = (model_q.size() > 0);
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
            @(posedge clk);
            #1;
            if (rise_cycle < 0 && rx_valid && !prev_valid) rise_cycle = c + 1;
            prev_valid = rx_valid;
        end
        rx_ready = 1'b0;
        if (abort_cycle < 0) modelFrame(data, stop_val, popped);
    endtask

    // One rx_ready pulse, checked against the model head.
    task automatic popOne(input string tag);
        checkOutput({tag, "_pre_valid"}, rx_valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            checkOutput({tag, "_pop_data"}, rx_data, model_q[0]);
            void'(model_q.pop_front());
        end
        rx_ready = 1'b1;
        idleCycles(1);
        rx_ready = 1'b0;
    endtask

    // One err_clr pulse; both flags must be low on the next cycle.
    task automatic clearErrors(input string tag);
        err_clr = 1'b1;
        idleCycles(1);
        err_clr     = 1'b0;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
        checkOutput({tag, "_clr_frame_err"}, frame_err, 1'b0);
        checkOutput({tag, "_clr_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        int         rise;
        logic [7:0] last;
        checks      = 0;
        errors      = 0;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
        rx          = 1'b1;
        reset       = 1'b1;
        rx_ready    = 1'b0;
        err_clr     = 1'b0;

        // Reset values.
        idleCycles(3);
        checkState("reset", 1'b0);
        checkOutput("reset_data", rx_data, 8'h00);
        reset = 1'b0;
        idleCycles(20);

        // Single byte: latency, contents, then one pop empties the FIFO.
        applyStimulus(8'hA5, 1'b1, -1, -1, rise);
        checkOutput("a5_latency", rise, 9 * CPB + CPB / 2 + 3);
        checkState("a5", 1'b0);
        popOne("a5");
        checkState("a5_popped", 1'b0);
        idleCycles(10);

        // Back-to-back frames fill the FIFO; a fifth byte overruns.
        applyStimulus(8'h00, 1'b1, -1, -1, rise);
        applyStimulus(8'hFF, 1'b1, -1, -1, rise);
        applyStimulus(8'h55, 1'b1, -1, -1, rise);
        applyStimulus(8'h3C, 1'b1, -1, -1, rise);
        checkState("b2b_full", 1'b0);
        applyStimulus(8'h77, 1'b1, -1, -1, rise);
        checkState("b2b_overrun", 1'b0);
        for (int i = 0; i < DEPTH; i++) popOne("b2b");
        checkState("b2b_drained", 1'b0);
        clearErrors("b2b");

        // Low stop bit, then the line stays low as a break.
        applyStimulus(8'h12, 1'b0, -1, -1, rise);
        checkState("ferr", 1'b0);
        idleCycles(300);
        checkState("break_hold", 1'b0);
        clearErrors("ferr");
        rx = 1'b1;
        idleCycles(30);
        applyStimulus(8'h6E, 1'b1, -1, -1, rise);
        checkState("after_break", 1'b0);
        popOne("after_break");
        idleCycles(10);

        // 30-cycle glitch on an idle line.
        for (int c = 0; c < 60; c++) begin
            rx = (c < 30) ? 1'b0 : 1'b1;
            idleCycles(1);
            if (c + 1 == 20) checkOutput("glitch_busy", rx_busy, 1'b1);
            if (c + 1 == 55) checkOutput("glitch_idle55", rx_busy, 1'b0);
        end
        checkState("glitch", 1'b0);

        // Reset in the middle of the data bits, with a byte already queued.
        applyStimulus(8'($urandom), 1'b1, -1, -1, rise);
        checkState("pre_rst", 1'b0);
        applyStimulus(8'h5A, 1'b1, -1, 4 * CPB + 20, rise);
        checkOutput("mid_busy", rx_busy, 1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        idleCycles(2);
        model_q.delete();
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
        checkState("mid_rst", 1'b0);
        checkOutput("mid_rst_data", rx_data, 8'h00);
        reset = 1'b0;
        idleCycles(20);
        applyStimulus(8'hC3, 1'b1, -1, -1, rise);
        checkState("c3", 1'b0);
        popOne("c3");

        // Full FIFO with a pop in the same cycle a fifth byte lands.
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'($urandom), 1'b1, -1, -1, rise);
        applyStimulus(8'h99, 1'b1, 9 * CPB + CPB / 2 + 2, -1, rise);
        checkState("simul", 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) popOne("simul");
        last = rx_data;
        popOne("simul_last");
        checkOutput("simul_last_99", last, 8'h99);
        checkState("simul_drained", 1'b0);

        // Randomized frames, pops, gaps and error clears.
        for (int n = 0; n < 14; n++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            applyStimulus(d, s, -1, -1, rise);
            checkState("rand", 1'b0);
            if (!s) begin
                rx = 1'b1;
                idleCycles(10);
            end
            if ($urandom_range(0, 1) == 1) popOne("rand");
            if ($urandom_range(0, 3) == 0) clearErrors("rand");
            idleCycles($urandom_range(0, 20));
        end
        while (model_q.size() > 0) popOne("rand_drain");
        checkState("final", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
